// File: rtl/module_bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter for the {Cout, sum} adder result.
// Define SEG7_EN to add an active-low 7-segment decode of the BCD result.
module module_bin_to_bcd_seq #(
    parameter int ANCHO   = 8,
    parameter int DIGITOS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inicio,
    input  logic [ANCHO:0]         dato,
    output logic                   ocupado,
    output logic                   listo,
    output logic [4*DIGITOS-1:0]   bcd
`ifdef SEG7_EN
    ,
    output logic [7*DIGITOS-1:0]   seg
`endif
);

    localparam int SW = 4 * DIGITOS;
    localparam int CW = $clog2(ANCHO + 1);

    typedef enum logic {
        REPOSO,
        CONVIRTIENDO
    } state_t;

    state_t          state_q, state_d;
    logic [ANCHO:0]  bin_q, bin_d;
    logic [SW-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   bcd_q, bcd_d;
    logic            listo_q, listo_d;
    logic [SW-1:0]   adj;
    logic [SW-1:0]   shifted;

    // Each digit is corrected on its own; the +3 never carries into the next digit.
    generate
        for (genvar gi = 0; gi < DIGITOS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                  ? scratch_q[4*gi +: 4] + 4'd3
                                  : scratch_q[4*gi +: 4];
        end
    endgenerate

    // The corrected MSB falls off the top; the digit-count constraint keeps it zero.
    assign shifted = SW'({adj, bin_q[ANCHO]});

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        listo_d   = 1'b0;
        case (state_q)
            REPOSO: begin
                if (inicio) begin
                    bin_d     = dato;
                    scratch_d = '0;
                    cnt_d     = CW'(ANCHO);
                    state_d   = CONVIRTIENDO;
                end
            end
            CONVIRTIENDO: begin
                scratch_d = shifted;
                bin_d     = {bin_q[ANCHO-1:0], 1'b0};
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    bcd_d   = shifted;
                    listo_d = 1'b1;
                    cnt_d   = '0;
                    state_d = REPOSO;
                end
            end
            default: state_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REPOSO;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            listo_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            listo_q   <= listo_d;
        end
    end

    assign ocupado = (state_q == CONVIRTIENDO);
    assign listo   = listo_q;
    assign bcd     = bcd_q;

`ifdef SEG7_EN
    // Segment order {g,f,e,d,c,b,a}, active low; non-decimal codes blank the digit.
    generate
        for (genvar gi = 0; gi < DIGITOS; gi++) begin : g_seg
            always_comb begin
                case (bcd_q[4*gi +: 4])
                    4'd0:    seg[7*gi +: 7] = 7'b1000000;
                    4'd1:    seg[7*gi +: 7] = 7'b1111001;
                    4'd2:    seg[7*gi +: 7] = 7'b0100100;
                    4'd3:    seg[7*gi +: 7] = 7'b0110000;
                    4'd4:    seg[7*gi +: 7] = 7'b0011001;
                    4'd5:    seg[7*gi +: 7] = 7'b0010010;
                    4'd6:    seg[7*gi +: 7] = 7'b0000010;
                    4'd7:    seg[7*gi +: 7] = 7'b1111000;
                    4'd8:    seg[7*gi +: 7] = 7'b0000000;
                    4'd9:    seg[7*gi +: 7] = 7'b0010000;
                    default: seg[7*gi +: 7] = 7'b1111111;
                endcase
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_module_bin_to_bcd_seq.sv
// Directed bench for module_bin_to_bcd_seq: latency, handshake, abort-on-reset and a full value sweep.
module tb_module_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        inicio;
    logic [8:0]  dato;
    logic        ocupado;
    logic        listo;
    logic [11:0] bcd;
`ifdef SEG7_EN
    logic [20:0] seg;
`endif

    int checks = 0;
    int errors = 0;

    module_bin_to_bcd_seq #(.ANCHO(8), .DIGITOS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .inicio  (inicio),
        .dato    (dato),
        .ocupado (ocupado),
        .listo   (listo),
        .bcd     (bcd)
`ifdef SEG7_EN
        ,
        .seg     (seg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a conversion, wait (bounded) for listo, check latency, busy flag and result.
    task automatic run(input string tag, input logic [8:0] v, input logic [11:0] exp);
        int  n;
        bit  busy_ok;
        dato    = v;
        inicio  = 1'b1;
        step();
        inicio  = 1'b0;
        n       = 0;
        busy_ok = 1'b1;
        while (!listo && n < 20) begin
            if (!ocupado) busy_ok = 1'b0;
            step();
            n++;
        end
        check({tag, "_lat"}, n, 9);
        check({tag, "_busy"}, {31'd0, busy_ok}, 1);
        check({tag, "_bcd"}, {20'd0, bcd}, {20'd0, exp});
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        int n;
        int pulses;
        rst    = 1'b1;
        inicio = 1'b0;
        dato   = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_ocupado", {31'd0, ocupado}, 0);
        check("rst_listo", {31'd0, listo}, 0);
        check("rst_bcd", {20'd0, bcd}, 0);
`ifdef SEG7_EN
        check("rst_seg", {11'd0, seg}, {11'd0, 7'b1000000, 7'b1000000, 7'b1000000});
`endif

        run("zero", 9'd0, 12'h000);
        check("zero_ocupado_listo_cycle", {31'd0, ocupado}, 0);
        step();
        check("zero_listo_drop", {31'd0, listo}, 0);
        $display("txn zero: bcd=%h", bcd);

        run("v510", 9'd510, 12'h510);
        $display("txn 510: bcd=%h", bcd);
        run("v99", 9'd99, 12'h099);
        $display("txn 99: bcd=%h", bcd);
        run("v256", 9'd256, 12'h256);
        $display("txn 256: bcd=%h", bcd);

        // inicio while busy must be ignored
        dato   = 9'd123;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        step(); step(); step();
        dato   = 9'd7;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (listo) begin
                pulses++;
                check("ignore_bcd", {20'd0, bcd}, {20'd0, 12'h123});
            end
            step();
        end
        check("ignore_pulses", pulses, 1);
        check("ignore_idle", {31'd0, ocupado}, 0);
        $display("txn ignore: bcd=%h pulses=%0d", bcd, pulses);

        // back-to-back with inicio held high
        dato   = 9'd200;
        inicio = 1'b1;
        step();
        n = 0;
        while (!listo && n < 20) begin step(); n++; end
        check("b2b_first_bcd", {20'd0, bcd}, {20'd0, 12'h200});
        dato = 9'd45;
        step();
        check("b2b_listo_drop", {31'd0, listo}, 0);
        check("b2b_hold_bcd", {20'd0, bcd}, {20'd0, 12'h200});
        n = 1;
        while (!listo && n < 20) begin
            if (n == 5) inicio = 1'b0;
            step();
            n++;
        end
        inicio = 1'b0;
        check("b2b_spacing", n, 10);
        check("b2b_second_bcd", {20'd0, bcd}, {20'd0, 12'h045});
        $display("txn b2b: bcd=%h spacing=%0d", bcd, n);
        step();

        // reset in the middle of a conversion
        dato   = 9'd300;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_ocupado", {31'd0, ocupado}, 0);
        check("abort_bcd", {20'd0, bcd}, 0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (listo) pulses++;
            step();
        end
        check("abort_no_listo", pulses, 0);
        run("after_abort", 9'd17, 12'h017);
        $display("txn abort: bcd=%h", bcd);

`ifdef SEG7_EN
        run("seg105", 9'd105, 12'h105);
        check("seg105_seg", {11'd0, seg}, {11'd0, 7'b1111001, 7'b1000000, 7'b0010010});
        $display("txn seg105: seg=%b", seg);
`endif

        for (int v = 0; v <= 510; v++) begin
            dato   = 9'(v);
            inicio = 1'b1;
            step();
            inicio = 1'b0;
            n = 0;
            while (!listo && n < 20) begin step(); n++; end
            check("sweep", {20'd0, bcd}, {20'd0, ref_bcd(v)});
        end
        $display("txn sweep: 511 values");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/module_bin_to_bcd_seq.md
Name: module_bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") that consumes the ANCHO+1-bit result of the ripple-carry adder stage, i.e. sum plus carry-out.
Converts one bit per clock and presents packed BCD digits for the display stage, with a start/done handshake.
Sits directly downstream of the adder, between it and the 7-segment display logic.

Parameters:
ANCHO, 8, adder operand width; the converter input is ANCHO+1 bits wide.
DIGITOS, 3, number of BCD digits produced; must satisfy 10^DIGITOS > 2^(ANCHO+1) - 1 (3 for ANCHO=8, max value 510).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
inicio  input  1  start request; sampled only while ocupado=0
dato  input  ANCHO+1  binary value from the adder, {Cout, sum}; captured on the accepting edge only
ocupado  output  1  high while a conversion is in progress
listo  output  1  one-cycle pulse; bcd is updated in this cycle
bcd  output  4*DIGITOS  packed BCD result; digit 0 (units) in bits [3:0]; held until the next completion

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset (rst=1 at an edge), which takes priority over everything:
  - state=REPOSO, ocupado=0, listo=0, bcd=0.
  - Shift register and iteration counter cleared.
  - A conversion in progress is abandoned; no listo is produced for it.
- FSM, two states:
  - REPOSO:
    - ocupado=0.
    - Edge with inicio=1: load bin_reg<=dato, scratch BCD<=0, cnt<=ANCHO; go to CONVIRTIENDO.
  - CONVIRTIENDO:
    - ocupado=1.
    - Each edge performs one iteration: first, every 4-bit scratch digit >=5 gets +3 (digits evaluated independently, same cycle); then {scratch, bin_reg} shifts left by 1.
    - cnt decrements each iteration.
    - On the iteration with cnt=0: bcd<=final scratch value (post-shift), listo<=1, go to REPOSO.
- Latency: the capture edge is E0. There are exactly ANCHO+1 iterations on edges E1..E(ANCHO+1). listo=1 and the new bcd are visible in the cycle after E(ANCHO+1). For ANCHO=8 that is 9 cycles after capture.
- listo is high for exactly one cycle and deasserts on the next edge unless another completion occurs.
- inicio while ocupado=1: ignored. There is no queueing and dato is not sampled.
- inicio during the listo cycle is legal because the state is already REPOSO. The new conversion starts, listo drops the next edge, and bcd keeps the previous result until the new one completes.
- inicio held high continuously: back-to-back conversions, one every ANCHO+2 cycles.
- Arithmetic: +3 correction is applied to 4-bit digits only and never carries between digits. The scratch register is 4*DIGITOS bits and the MSB shifted out is discarded; the parameter constraint guarantees no loss.
- bcd and listo are registered outputs; ocupado decodes directly from the state register.

Optional Feature:
Macro SEG7_EN.
- Defined:
  - Adds output port seg, 7*DIGITOS bits, active-low segments {g,f,e,d,c,b,a} per digit; digit 0 in bits [6:0].
  - seg is decoded combinationally from the bcd register.
  - Codes 0-9 use the standard patterns, e.g. 0=7'b1000000, 1=7'b1111001, 5=7'b0010010. Codes 10-15 (unreachable) give all segments off, 7'b1111111.
  - After reset, seg shows "000".
- Not defined: the seg port and decoder are absent; all other behaviour is identical.

Test Plan:
- rst, then dato=0, inicio pulse -> listo exactly 9 cycles after capture edge, bcd=12'h000, ocupado high for those 9 cycles.
- dato=9'd510 (255+255 with carry) -> bcd=12'h510; dato=9'd99 -> bcd=12'h099; dato=9'd256 -> bcd=12'h256.
- Capture dato=9'd123; 3 cycles later assert inicio with dato=9'd7 -> inicio ignored, result bcd=12'h123, single listo.
- inicio held high with dato=200 then 45 from the listo cycle -> bcd=12'h200 then 12'h045, listo pulses 10 cycles apart.
- Start dato=9'd300, assert rst at iteration 4 -> ocupado=0, listo never pulses, bcd=12'h000; the next conversion of 17 -> 12'h017.
- Exhaustive sweep dato=0..510 against a reference model; with SEG7_EN, dato=105 -> seg={7'b1111001, 7'b1000000, 7'b0010010}.
